// File: rtl/note_recorder.sv
// rtl/note_recorder.sv - record/replay sequencer for the key pattern feeding the sound generator
//
// Purpose: passes the live pattern P = {high, low, key} through with one cycle
// of latency. While record_en is high it stores each stable pattern together
// with its hold time (in prescaler ticks). A replay pulse plays the stored
// sequence back with the original timing.
//
// Ports:
//   sys_CLK, sys_RST            clock, asynchronous active-high reset
//   key, high, low              live keyboard pattern
//   record_en                   level, high requests recording
//   replay                      single-cycle playback start / restart pulse
//   out_key, out_high, out_low  pattern to the sound generator (registered)
//   recording, playing          state flags (registered)
//   full, count                 buffer occupancy

module note_recorder #(
   parameter int DEPTH    = 32,
   parameter int DUR_W    = 12,
   parameter int TICK_DIV = 500000
) (
   input  logic                   sys_CLK,
   input  logic                   sys_RST,
   input  logic [6:0]             key,
   input  logic                   high,
   input  logic                   low,
   input  logic                   record_en,
   input  logic                   replay,
   output logic [6:0]             out_key,
   output logic                   out_high,
   output logic                   out_low,
   output logic                   recording,
   output logic                   playing,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DUR_W-1:0] DUR_MAX = '1;
   localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, REC, PLAY} state_t;

   state_t               state;
   state_t               state_nxt;

   logic [8:0]           live_p;
   logic [PW-1:0]        presc;
   logic                 tick;
   logic                 enter;

   logic [8:0]           seg_p;
   logic [DUR_W-1:0]     seg_dur;
   logic [DUR_W-1:0]     close_dur;
   logic                 seg_close;
   logic                 wr_en;

   logic [8+DUR_W:0]     mem [DEPTH];
   logic [AW-1:0]        idx;
   logic [AW-1:0]        rd_idx;
   logic [8+DUR_W:0]     rd_word;
   logic [DUR_W-1:0]     remain;
   logic                 play_start;
   logic                 expire;
   logic                 last;

   logic [8:0]           out_p_nxt;
   logic                 recording_nxt;
   logic                 playing_nxt;

   assign live_p = {high, low, key};

   // ---------------- prescaler ----------------
   assign tick  = (presc == PW'(TICK_DIV - 1));
   // A replay during PLAY counts as a fresh entry so the restarted entry 0
   // gets its full duration.
   assign enter = (state_nxt != state) || (state == PLAY && replay);

   always_ff @(posedge sys_CLK or posedge sys_RST) begin
      if (sys_RST)
         presc <= '0;
      else if (enter || tick)
         presc <= '0;
      else
         presc <= presc + 1'b1;
   end

   // ---------------- recording ----------------
   // A tick landing on the closing cycle belongs to the segment being closed.
   assign close_dur = (tick && seg_dur != DUR_MAX) ? seg_dur + 1'b1 : seg_dur;
   assign seg_close = (state == REC) &&
                      ((live_p != seg_p) || !record_en || (tick && seg_dur == DUR_MAX));
   assign wr_en     = seg_close && (close_dur != '0) && !full;

   always_ff @(posedge sys_CLK or posedge sys_RST) begin
      if (sys_RST) begin
         seg_p   <= '0;
         seg_dur <= '0;
      end else if (state != REC || seg_close) begin
         // Outside REC the segment tracks the live pattern, so REC entry
         // starts with the pattern sampled alongside record_en.
         seg_p   <= live_p;
         seg_dur <= '0;
      end else if (tick) begin
         seg_dur <= close_dur;
      end
   end

   always_ff @(posedge sys_CLK) begin
      if (wr_en)
         mem[count[AW-1:0]] <= {seg_p, close_dur};
   end

   always_ff @(posedge sys_CLK or posedge sys_RST) begin
      if (sys_RST) begin
         count <= '0;
         full  <= 1'b0;
      end else if (state == IDLE && record_en) begin
         count <= '0;
         full  <= 1'b0;
      end else if (wr_en) begin
         count <= count + 1'b1;
         full  <= (count + 1'b1 == DEPTH_C);
      end
   end

   // ---------------- playback ----------------
   assign play_start = replay &&
                       ((state == IDLE && !record_en && count != '0) || state == PLAY);
   assign expire     = (state == PLAY) && tick && (remain == DUR_W'(1));
   assign last       = ({1'b0, idx} == count - 1'b1);
   assign rd_idx     = play_start ? '0 : idx + 1'b1;
   assign rd_word    = mem[rd_idx];

   always_ff @(posedge sys_CLK or posedge sys_RST) begin
      if (sys_RST) begin
         idx    <= '0;
         remain <= '0;
      end else if (play_start) begin
         idx    <= '0;
         remain <= rd_word[DUR_W-1:0];
      end else if (expire && !last) begin
         idx    <= idx + 1'b1;
         remain <= rd_word[DUR_W-1:0];
      end else if (state == PLAY && tick) begin
         remain <= remain - 1'b1;
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge sys_CLK or posedge sys_RST) begin
      if (sys_RST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (record_en)
               state_nxt = REC;
            else if (replay && count != '0)
               state_nxt = PLAY;
         end
         REC: begin
            if (!record_en)
               state_nxt = IDLE;
         end
         PLAY: begin
            if (!replay && expire && last)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      out_p_nxt     = live_p;
      recording_nxt = (state_nxt == REC);
      playing_nxt   = (state_nxt == PLAY);
      if (state_nxt == PLAY) begin
         if (play_start || expire)
            out_p_nxt = rd_word[8+DUR_W:DUR_W];
         else
            out_p_nxt = {out_high, out_low, out_key};
      end
   end

   always_ff @(posedge sys_CLK or posedge sys_RST) begin
      if (sys_RST) begin
         out_key   <= '0;
         out_high  <= 1'b0;
         out_low   <= 1'b0;
         recording <= 1'b0;
         playing   <= 1'b0;
      end else begin
         {out_high, out_low, out_key} <= out_p_nxt;
         recording <= recording_nxt;
         playing   <= playing_nxt;
      end
   end

endmodule

// File: tb/tb_note_recorder.sv
// tb/tb_note_recorder.sv - self-checking bench for note_recorder

module tb_note_recorder;

   localparam int TD = 4;
   localparam int DP = 4;
   localparam int M_IDLE = 0;
   localparam int M_REC  = 1;
   localparam int M_PLAY = 2;

   logic       sys_CLK;
   logic       sys_RST;
   logic [6:0] key;
   logic       high;
   logic       low;
   logic       record_en;
   logic       replay;
   logic [6:0] out_key;
   logic       out_high;
   logic       out_low;
   logic       recording;
   logic       playing;
   logic       full;
   logic [2:0] count;

   note_recorder #(.DEPTH(DP), .DUR_W(12), .TICK_DIV(TD)) dut (
      .sys_CLK   (sys_CLK),
      .sys_RST   (sys_RST),
      .key       (key),
      .high      (high),
      .low       (low),
      .record_en (record_en),
      .replay    (replay),
      .out_key   (out_key),
      .out_high  (out_high),
      .out_low   (out_low),
      .recording (recording),
      .playing   (playing),
      .full      (full),
      .count     (count)
   );

   initial begin
      sys_CLK = 1'b0;
      forever #5 sys_CLK = ~sys_CLK;
   end

   int n_checks = 0;
   int n_errs   = 0;
   bit cmp_on   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [8:0] p;
      int         dur;
   } ent_t;

   ent_t       buf_q[$];
   logic [8:0] play_q[$];
   int         mode;
   logic [8:0] seg_pat;
   int         seg_ticks;
   int         rec_k;
   logic [8:0] exp_p;
   logic       exp_rec;
   logic       exp_play;

   // Playback is the stored list expanded to one pattern per clock cycle.
   task automatic start_play();
      play_q.delete();
      foreach (buf_q[i])
         repeat (buf_q[i].dur * TD) play_q.push_back(buf_q[i].p);
   endtask

   task automatic model_step();
      logic [8:0] lp;
      int         t;
      lp = {high, low, key};
      case (mode)
         M_IDLE: begin
            if (record_en) begin
               mode = M_REC;
               buf_q.delete();
               seg_pat   = lp;
               seg_ticks = 0;
               rec_k     = 0;
            end else if (replay && buf_q.size() > 0) begin
               start_play();
               mode = M_PLAY;
            end
         end
         M_REC: begin
            t = ((rec_k % TD) == TD - 1) ? 1 : 0;
            rec_k++;
            if (lp != seg_pat || !record_en) begin
               if (seg_ticks + t > 0 && buf_q.size() < DP)
                  buf_q.push_back('{seg_pat, seg_ticks + t});
               seg_pat   = lp;
               seg_ticks = 0;
            end else begin
               seg_ticks += t;
            end
            if (!record_en) mode = M_IDLE;
         end
         default: begin
            if (replay) start_play();
            else if (play_q.size() == 0) mode = M_IDLE;
         end
      endcase
      if (mode == M_PLAY) exp_p = play_q.pop_front();
      else exp_p = lp;
      exp_rec  = (mode == M_REC);
      exp_play = (mode == M_PLAY);
   endtask

   initial begin
      mode = M_IDLE;
      forever begin
         @(posedge sys_CLK or posedge sys_RST);
         if (sys_RST) begin
            mode = M_IDLE;
            buf_q.delete();
            play_q.delete();
            exp_p    = '0;
            exp_rec  = 1'b0;
            exp_play = 1'b0;
         end else begin
            model_step();
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge sys_CLK);
         if (cmp_on && !sys_RST) begin
            chk("out_p", {out_high, out_low, out_key}, exp_p);
            chk("recording", recording, exp_rec);
            chk("playing", playing, exp_play);
            chk("count", count, buf_q.size());
            chk("full", full, buf_q.size() == DP);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(negedge sys_CLK);
   endtask

   task automatic drive(input logic [6:0] k, input logic h, input logic l);
      key  = k;
      high = h;
      low  = l;
   endtask

   initial begin
      sys_RST = 1'b1;
      drive(7'd0, 1'b0, 1'b0);
      record_en = 1'b0;
      replay    = 1'b0;
      step(2);
      chk("rst_out", {out_high, out_low, out_key}, 9'd0);
      chk("rst_rec", recording, 1'b0);
      chk("rst_play", playing, 1'b0);
      chk("rst_full", full, 1'b0);
      chk("rst_count", count, 3'd0);
      #2 sys_RST = 1'b0;
      cmp_on = 1'b1;
      step(1);

      // live pass-through
      drive(7'b0000001, 1'b1, 1'b0);
      step(1);
      chk("live_out", {out_high, out_low, out_key}, 9'h101);
      chk("live_rec", recording, 1'b0);
      chk("live_play", playing, 1'b0);

      // record key1 for 12 cycles, key2 for 8 cycles
      record_en = 1'b1;
      step(1);
      chk("rec_on", recording, 1'b1);
      step(11);
      drive(7'b0000010, 1'b1, 1'b0);
      step(8);
      record_en = 1'b0;
      step(1);
      chk("rec_off", recording, 1'b0);
      chk("rec_count", count, 3'd2);
      chk("model_n", buf_q.size(), 2);
      chk("model_e0p", buf_q[0].p, 9'h101);
      chk("model_e0d", buf_q[0].dur, 3);
      chk("model_e1p", buf_q[1].p, 9'h102);
      chk("model_e1d", buf_q[1].dur, 2);

      // replay with a different live pattern present
      drive(7'b1000000, 1'b0, 1'b1);
      replay = 1'b1;
      step(1);
      replay = 1'b0;
      for (int k = 1; k <= 21; k++) begin
         if (k > 1) step(1);
         if (k == 1) chk("play_on", playing, 1'b1);
         if (k == 1 || k == 12) chk("play_a", out_key, 7'b0000001);
         if (k == 13 || k == 20) chk("play_b", out_key, 7'b0000010);
         if (k == 21) begin
            chk("play_off", playing, 1'b0);
            chk("play_live", {out_high, out_low, out_key}, 9'b0_1_1000000);
         end
      end

      // glitch shorter than one tick at the start of a recording
      drive(7'b0000100, 1'b0, 1'b0);
      record_en = 1'b1;
      step(1);
      drive(7'b0100000, 1'b0, 1'b0);
      step(2);
      drive(7'b0000100, 1'b0, 1'b0);
      step(1);
      chk("glitch_cnt", count, 3'd0);
      step(8);
      record_en = 1'b0;
      step(1);
      chk("glitch_final", count, 3'd1);
      chk("glitch_e0p", buf_q[0].p, 9'h004);
      chk("glitch_e0d", buf_q[0].dur, 3);

      // six one-tick patterns into a four-entry buffer
      for (int i = 0; i < 6; i++) begin
         drive(7'(1 << i), 1'b0, 1'b1);
         if (i == 0) record_en = 1'b1;
         step(4);
      end
      record_en = 1'b0;
      step(1);
      chk("full_flag", full, 1'b1);
      chk("full_count", count, 3'd4);
      replay = 1'b1;
      step(1);
      replay = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         if (k > 1) step(1);
         if (k == 1 || k == 4) chk("full_s0", out_key, 7'b0000001);
         if (k == 5) chk("full_s1", out_key, 7'b0000010);
         if (k == 13 || k == 16) chk("full_s3", out_key, 7'b0001000);
         if (k == 17) begin
            chk("full_end", playing, 1'b0);
            chk("full_live", out_key, 7'b0100000);
         end
      end

      // restart mid-playback
      replay = 1'b1;
      step(1);
      replay = 1'b0;
      step(5);
      chk("pre_restart", out_key, 7'b0000010);
      replay = 1'b1;
      step(1);
      replay = 1'b0;
      chk("restart_s0", out_key, 7'b0000001);
      chk("restart_on", playing, 1'b1);
      step(4);
      chk("restart_s1", out_key, 7'b0000010);

      // reset mid-playback
      #2 sys_RST = 1'b1;
      #1;
      chk("mid_rst_out", {out_high, out_low, out_key}, 9'd0);
      chk("mid_rst_play", playing, 1'b0);
      chk("mid_rst_count", count, 3'd0);
      step(1);
      #2 sys_RST = 1'b0;
      step(2);
      chk("post_rst_play", playing, 1'b0);
      chk("post_rst_out", {out_high, out_low, out_key}, 9'b0_1_0100000);
      chk("post_rst_count", count, 3'd0);
      replay = 1'b1;
      step(1);
      replay = 1'b0;
      chk("empty_replay", playing, 1'b0);
      step(2);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
